// File: rtl/zx_video_gen_if.sv
// Signal bundle between the ZX81-style video generator, its display RAM and
// the scan doubler. The generator side is the master: it drives the RAM read
// strobe/address and the csync/video link, and it receives the pixel enable,
// mode controls and RAM read data.
interface zx_video_gen_if;
  logic        ce_pix;
  logic        ntsc;
  logic        invert;
  logic        border;
  logic        rd_en;
  logic [12:0] rd_addr;
  logic [7:0]  rd_data;
  logic        csync;
  logic        video;
  logic        frame_start;

  modport master (
    input  ce_pix,
    input  ntsc,
    input  invert,
    input  border,
    input  rd_data,
    output rd_en,
    output rd_addr,
    output csync,
    output video,
    output frame_start
  );

  modport slave (
    output ce_pix,
    output ntsc,
    output invert,
    output border,
    output rd_data,
    input  rd_en,
    input  rd_addr,
    input  csync,
    input  video,
    input  frame_start
  );
endinterface

// File: rtl/zx_video_gen.sv
// ZX81-style composite video generator. Counts 414 pixels per line and
// 312 (PAL) or 262 (NTSC) lines per frame at the ce_pix rate, fetches a
// 256x192 bitmap byte-wise from a synchronous display RAM two pixels ahead
// of use, and serialises it MSB first inside a border. csync, video and
// frame_start are all registered from the same counter state, so they carry
// zero relative skew.
module zx_video_gen #(
  parameter int ACT_COL = 96,
  parameter int HS_LEN  = 30,
  parameter int VS_LEN  = 384
) (
  input  logic          clk,
  input  logic          reset,
  zx_video_gen_if.master bus
);

  localparam logic [8:0] H_LAST         = 9'd413;
  localparam logic [8:0] V_LAST_PAL     = 9'd311;
  localparam logic [8:0] V_LAST_NTSC    = 9'd261;
  localparam logic [8:0] ACT_FIRST_PAL  = 9'd56;
  localparam logic [8:0] ACT_FIRST_NTSC = 9'd32;
  localparam logic [8:0] ACT_ROWS       = 9'd192;
  localparam logic [8:0] VS_LINES       = 9'd4;
  localparam logic [8:0] HS_END         = 9'(HS_LEN);
  localparam logic [8:0] VS_END         = 9'(VS_LEN);
  localparam logic [8:0] COL_FIRST      = 9'(ACT_COL);
  localparam logic [8:0] COL_LAST       = 9'(ACT_COL + 255);
  // The RAM answers one tick after the strobe, and the byte must sit in the
  // shift register one tick before its first pixel, hence the -2/-1 offsets.
  localparam logic [8:0] FETCH_FIRST    = 9'(ACT_COL - 2);
  localparam logic [8:0] FETCH_LAST     = 9'(ACT_COL - 2 + 248);
  localparam logic [8:0] LOAD_FIRST     = 9'(ACT_COL - 1);
  localparam logic [8:0] LOAD_LAST      = 9'(ACT_COL - 1 + 248);

  // Sync is low for the long vsync pulse on lines 0..3, else the short hsync.
  function automatic logic sync_is_low(input logic [8:0] h, input logic [8:0] v);
    if (v < VS_LINES) begin
      return h < VS_END;
    end
    return h < HS_END;
  endfunction

  // Sync-low pixels are forced black; the border level applies elsewhere
  // outside the bitmap.
  function automatic logic video_level(input logic sync_low, input logic in_active,
                                       input logic pixel, input logic border_lvl);
    if (sync_low) begin
      return 1'b0;
    end
    if (in_active) begin
      return pixel;
    end
    return border_lvl;
  endfunction

  logic [8:0] h_cnt;
  logic [8:0] v_cnt;
  logic       ntsc_mode;
  logic [7:0] shreg;

  logic        csync_q;
  logic        video_q;
  logic        frame_start_q;
  logic        rd_en_q;
  logic [12:0] rd_addr_q;

  logic [8:0] v_last;
  logic [8:0] act_first;
  logic       act_line;
  logic       act_col;
  logic [7:0] row;
  logic [4:0] fetch_k;
  logic       fetch_tick;
  logic       load_tick;
  logic       sync_low;
  logic       video_nxt;

  // Decode the current counter position into line/column qualifiers.
  always_comb begin
    v_last     = ntsc_mode ? V_LAST_NTSC : V_LAST_PAL;
    act_first  = ntsc_mode ? ACT_FIRST_NTSC : ACT_FIRST_PAL;
    act_line   = (v_cnt >= act_first) && (v_cnt < act_first + ACT_ROWS);
    act_col    = (h_cnt >= COL_FIRST) && (h_cnt <= COL_LAST);
    row        = 8'(v_cnt - act_first);
    fetch_k    = 5'((h_cnt - FETCH_FIRST) >> 3);
    fetch_tick = act_line && (h_cnt >= FETCH_FIRST) && (h_cnt <= FETCH_LAST) &&
                 (h_cnt[2:0] == FETCH_FIRST[2:0]);
    load_tick  = act_line && (h_cnt >= LOAD_FIRST) && (h_cnt <= LOAD_LAST) &&
                 (h_cnt[2:0] == LOAD_FIRST[2:0]);
    sync_low   = sync_is_low(h_cnt, v_cnt);
    video_nxt  = video_level(sync_low, act_line && act_col,
                             shreg[7] ^ bus.invert, bus.border);
  end

  // Pixel/line counters; the frame mode is only re-sampled at frame wrap so
  // a mid-frame ntsc change cannot produce a torn frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      ntsc_mode <= bus.ntsc;
    end else if (bus.ce_pix) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == v_last) begin
          v_cnt     <= '0;
          ntsc_mode <= bus.ntsc;
        end else begin
          v_cnt <= v_cnt + 9'd1;
        end
      end else begin
        h_cnt <= h_cnt + 9'd1;
      end
    end
  end

  // Pixel shift register: load the fetched byte, otherwise shift out MSB
  // first across the active columns. On the last pixel of a byte the load
  // wins, which is exactly when that last bit has already been used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
    end else if (bus.ce_pix) begin
      if (load_tick) begin
        shreg <= bus.rd_data;
      end else if (act_line && act_col) begin
        shreg <= {shreg[6:0], 1'b0};
      end
    end
  end

  // Registered outputs, all updated from the same tick's counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csync_q       <= 1'b1;
      video_q       <= 1'b0;
      frame_start_q <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
    end else if (bus.ce_pix) begin
      csync_q       <= ~sync_low;
      video_q       <= video_nxt;
      frame_start_q <= (h_cnt == 9'd0) && (v_cnt == 9'd0);
      rd_en_q       <= fetch_tick;
      if (fetch_tick) begin
        rd_addr_q <= {row, fetch_k};
      end
    end
  end

  assign bus.csync       = csync_q;
  assign bus.video       = video_q;
  assign bus.frame_start = frame_start_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr     = rd_addr_q;

endmodule

// File: tb/tb_zx_video_gen.sv
// Bench for zx_video_gen: a tick-indexed reference model derived from line
// and column arithmetic, a per-cycle output compare, per-line statistics
// and directed literal checks for sync widths, fetch sequence, active line
// placement, invert/border levels and asynchronous reset.
module tb_zx_video_gen;
  localparam int ACT_COL = 96;
  localparam int HS_LEN  = 30;
  localparam int VS_LEN  = 384;
  localparam int HT      = 414;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  zx_video_gen_if bus();

  zx_video_gen #(.ACT_COL(ACT_COL), .HS_LEN(HS_LEN), .VS_LEN(VS_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Display RAM: data presented while the strobe is held, junk otherwise.
  logic [7:0] ram [0:8191];
  assign bus.rd_data = bus.rd_en ? ram[bus.rd_addr] : 8'h5A;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_t;
  bit          m_mode;
  int          m_h, m_v;
  bit          m_ticked;
  logic        e_cs, e_vid, e_fs, e_rd;
  logic [12:0] e_addr;

  task automatic model_tick();
    int h, v, lines, first, x, row;
    bit slow, actl, actc;
    logic [7:0] b;
    h     = m_t % HT;
    lines = m_mode ? 262 : 312;
    v     = (m_t / HT) % lines;
    first = m_mode ? 32 : 56;
    slow  = (v < 4) ? (h < VS_LEN) : (h < HS_LEN);
    actl  = (v >= first) && (v < first + 192);
    actc  = (h >= ACT_COL) && (h < ACT_COL + 256);
    x     = h - ACT_COL;
    row   = v - first;
    e_cs  = !slow;
    if (slow) e_vid = 1'b0;
    else if (actl && actc) begin
      b     = ram[row * 32 + x / 8];
      e_vid = b[7 - x % 8] ^ bus.invert;
    end else e_vid = bus.border;
    e_fs = (h == 0) && (v == 0);
    e_rd = actl && (h >= ACT_COL - 2) && (h < ACT_COL - 2 + 256) && ((h - (ACT_COL - 2)) % 8 == 0);
    if (e_rd) e_addr = 13'(row * 32 + (h - ACT_COL + 2) / 8);
    m_h = h;
    m_v = v;
    m_ticked = 1'b1;
    m_t++;
  endtask

  always @(posedge clk) begin
    m_ticked = 1'b0;
    if (reset) begin
      m_t = 0; m_mode = bus.ntsc;
      e_cs = 1'b1; e_vid = 1'b0; e_fs = 1'b0; e_rd = 1'b0; e_addr = '0;
    end else if (bus.ce_pix) begin
      model_tick();
    end
  end

  // ---------------- compare and per-line statistics ----------------
  int   ln_cs [0:319];
  int   ln_vid[0:319];
  int   ln_rd [0:319];
  int   acc_cs, acc_vid, acc_rd;
  logic vbits [0:255];
  int   fetch_h[$];
  int   fetch_a[$];

  always @(posedge clk) begin
    #1;
    check("outputs", {bus.csync, bus.video, bus.frame_start, bus.rd_en, bus.rd_addr},
          {e_cs, e_vid, e_fs, e_rd, e_addr});
    if (m_ticked) begin
      if (m_h == 0) begin acc_cs = 0; acc_vid = 0; acc_rd = 0; end
      if (!bus.csync) acc_cs++;
      if (bus.video)  acc_vid++;
      if (bus.rd_en)  acc_rd++;
      if (m_v == 56 && m_h >= ACT_COL && m_h < ACT_COL + 256) vbits[m_h - ACT_COL] = bus.video;
      if (m_v == 56 && bus.rd_en) begin
        fetch_h.push_back(m_h);
        fetch_a.push_back(int'(bus.rd_addr));
      end
      if (m_h == HT - 1) begin
        ln_cs[m_v] = acc_cs; ln_vid[m_v] = acc_vid; ln_rd[m_v] = acc_rd;
      end
    end
  end

  // ---------------- stimulus ----------------
  int ticks = 0;
  bit div2  = 1'b1;

  task automatic run_to(input int target);
    while (ticks < target) begin
      @(negedge clk);
      bus.ce_pix = 1'b1;
      ticks++;
      if (div2) begin
        @(negedge clk);
        bus.ce_pix = 1'b0;
      end
    end
    if (!div2) begin
      @(negedge clk);
      bus.ce_pix = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] b;
    bus.ce_pix = 1'b0; bus.ntsc = 1'b0; bus.invert = 1'b0; bus.border = 1'b0;
    for (int a = 0; a < 8192; a++)
      ram[a] = ((a >> 5) == 0) ? 8'(a & 31) : 8'((a * 37) ^ 8'h5C);
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", {bus.csync, bus.video, bus.frame_start, bus.rd_en, bus.rd_addr},
          {1'b1, 1'b0, 1'b0, 1'b0, 13'h0});

    // PAL, ce_pix every second clock
    @(negedge clk);
    reset = 1'b0;
    run_to(1);
    check("first_frame_start", bus.frame_start, 1);
    check("first_csync", bus.csync, 0);
    run_to(10 * HT + 7);
    bus.ntsc = 1'b1;
    run_to(20 * HT + 100);
    bus.border = 1'b1;
    run_to(20 * HT + 150);
    bus.border = 1'b0;
    run_to(57 * HT);

    for (int v = 0; v < 6; v++) check("pal_sync_low_width", ln_cs[v], (v < 4) ? 384 : 30);
    check("pal_sync_low_line55", ln_cs[55], 30);
    check("border_pulse_line20", ln_vid[20], 50);
    check("border_off_line21", ln_vid[21], 0);
    check("pal_no_fetch_line32", ln_rd[32], 0);
    check("pal_no_fetch_line55", ln_rd[55], 0);
    check("pal_fetch_line56", ln_rd[56], 32);
    check("line56_white_count", ln_vid[56], 80);
    check("fetch_count", fetch_h.size(), 32);
    for (int k = 0; k < 32 && k < fetch_h.size(); k++) begin
      check("fetch_h", fetch_h[k], 94 + 8 * k);
      check("fetch_addr", fetch_a[k], k);
    end
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 8; j++) b[7 - j] = vbits[8 * k + j];
      check("line56_byte", b, k);
    end

    run_to(57 * HT + 120);
    bus.invert = 1'b1;
    run_to(57 * HT + 130);
    bus.invert = 1'b0;
    run_to(57 * HT + 200);

    // asynchronous reset in the middle of an active line
    reset = 1'b1;
    #1;
    check("midline_reset_csync", bus.csync, 1);
    check("midline_reset_video", bus.video, 0);
    check("midline_reset_rd_en", bus.rd_en, 0);
    check("midline_reset_addr", bus.rd_addr, 0);

    // NTSC (latched at reset), invert on, border on, blank RAM, ce every clock
    bus.invert = 1'b1; bus.border = 1'b1;
    for (int a = 0; a < 8192; a++) ram[a] = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ticks = 0;
    div2 = 1'b0;
    run_to(1);
    check("reset_rel_frame_start", bus.frame_start, 1);
    check("reset_rel_csync", bus.csync, 0);
    run_to(31 * HT);
    bus.border = 1'b0;
    run_to(34 * HT);

    check("ntsc_vsync_low_width", ln_cs[0], 384);
    check("ntsc_vsync_white", ln_vid[0], 30);
    check("ntsc_border_white", ln_vid[5], 384);
    check("ntsc_line31_white", ln_vid[31], 0);
    check("ntsc_line31_fetch", ln_rd[31], 0);
    check("ntsc_line32_fetch", ln_rd[32], 32);
    check("ntsc_line32_white", ln_vid[32], 256);
    check("ntsc_line33_white", ln_vid[33], 256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/zx_video_gen.md
# zx_video_gen

ZX81-style composite video generator: produces the active-low composite sync and 1-bit video stream that the design's scan doubler consumes, at 6.5 MHz pixel rate, 414 pixels per 64 µs line. It fetches a 256×192 bitmap byte-wise from an external synchronous display RAM and serialises it MSB first inside a programmable border. It is the transmitter end of the csync/video link feeding the scandoubler.

## Interface
Parameters:
- ACT_COL, 96, first active column (multiple of 8, ≥ 8)
- HS_LEN, 30, normal sync pulse length in pixels (must be < 45)
- VS_LEN, 384, vsync-line sync-low length in pixels (must be > 45)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce_pix  in  1  6.5 MHz pixel enable; all state advances only when high
- ntsc  in  1  0: 312-line frame, 1: 262-line frame; sampled at frame wrap
- invert  in  1  invert active-area pixels
- border  in  1  video level outside active area
- rd_en  out  1  display RAM read strobe, one ce_pix tick wide
- rd_addr  out  13  {row[7:0], byte[4:0]}, row 0..191, byte 0..31
- rd_data  in  8  RAM data, valid at the ce_pix tick after rd_en
- csync  out  1  composite sync, 0 = sync
- video  out  1  pixel output, 1 = white
- frame_start  out  1  one-tick pulse at start of line 0

## Operation
- h_cnt 9-bit, 0..413, wraps to 0; v_cnt 9-bit, increments on h_cnt wrap, wraps after 311 (PAL) or 261 (NTSC).
- Frame mode register latched from ntsc when v_cnt wraps and on reset (reset latches current ntsc); changes mid-frame have no effect until next wrap.
- Vsync lines: v_cnt 0..3. Sync low for h_cnt < VS_LEN, high otherwise.
- Normal lines: sync low for h_cnt < HS_LEN, high otherwise.
- Active lines: PAL v_cnt 56..247, NTSC 32..223; row = v_cnt − first active line.
- Active columns: h_cnt ACT_COL..ACT_COL+255; pixel x = h_cnt − ACT_COL.
- Fetch: on active lines, rd_en=1 with rd_addr={row,k} during tick h_cnt = ACT_COL−2+8k, k=0..31; rd_en=0 at all other ticks. rd_addr holds last value when idle.
- Load: at tick h_cnt = ACT_COL−1+8k, shreg <= rd_data.
- Shift: at ticks h_cnt in active range, output bit = shreg[7] ^ invert, shreg <= shreg<<1.
- Outside active area (including all vsync and border lines), video = border; during sync-low pixels video = 0 regardless of border.
- frame_start = 1 for the tick where v_cnt=0, h_cnt=0.

## Timing
- csync, video, frame_start are registered; each reflects the h_cnt/v_cnt of the ce_pix tick that updated it and holds until the next ce_pix. No combinational path from any input to any output.
- Pixel x visible from the tick at h_cnt=ACT_COL+x until next tick; csync aligned identically (zero skew between csync and video).
- rd_data latency exactly one ce_pix tick; rd_data ignored at every other tick.
- invert and border sampled at the tick the pixel is produced; mid-line changes take effect on next pixel.
- Reset (any time, including mid-line/mid-fetch): h_cnt=0, v_cnt=0, shreg=0, csync=1, video=0, rd_en=0, rd_addr=0, frame_start=0. First ce_pix after release processes h_cnt=0, v_cnt=0 (sync low, frame_start=1).
- ce_pix low: all registers hold, outputs static.

## Test plan
- PAL free-run, ce_pix every 2nd clk: csync low 30 ticks per normal line, period 414 ticks; 312 lines per frame; frame_start every 129168 ticks.
- Vsync: lines 0..3 csync low 384 ticks then high 30; measured low width > 45 pixels on those lines only.
- Pattern RAM with rd_data = byte index k, row 0: video on line 56 columns 96..351 reproduces bytes 0x00..0x1F MSB first; rd_addr sequence 0x0000..0x001F at h_cnt 94,102,..,342.
- invert=1, border=1, RAM all 0x00: active pixels 1, border 1, sync-low pixels 0.
- ntsc 0→1 toggled at v_cnt=100: current frame still 312 lines, next frame 262 lines, active starts line 32.
- Reset asserted at h_cnt=200 of an active line: outputs immediately csync=1, video=0, rd_en=0; after release first tick gives frame_start=1, csync=0.
